// File: rtl/mod_accum_pkg.sv
// Shared widths, default modulus, sequencer state type and the accumulator
// control payload for mod_accum_seq.
package mod_accum_pkg;

    localparam int unsigned DIGIT_W         = 21;
    localparam int unsigned ACC_W           = 22;
    localparam int unsigned LEN_W           = 16;
    localparam int unsigned MODULUS_DEFAULT = 177147;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_RUN,
        ST_DRAIN,
        ST_HOLD
    } state_e;

    // Everything the sequencer drives into the external accumulator.
    typedef struct packed {
        logic               clear_3;
        logic               clear_2;
        logic               clear_1;
        logic               trunc_ena;
        logic [DIGIT_W-1:0] digit;
    } acc_ctrl_t;

    // Idle/flush view of the accumulator controls: all stages held clear.
    localparam acc_ctrl_t ACC_CTRL_IDLE = '{
        clear_3:   1'b1,
        clear_2:   1'b1,
        clear_1:   1'b1,
        trunc_ena: 1'b0,
        digit:     '0
    };

endpackage

// File: rtl/mod_accum_golden.sv
// Golden modular accumulator: sums accepted operands modulo MODULUS and
// flags a sticky error when the captured result disagrees at HOLD entry.
module mod_accum_golden
    import mod_accum_pkg::*;
#(
    parameter int unsigned MODULUS = MODULUS_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               acc_en,
    input  logic [DIGIT_W-1:0] data,
    input  logic               cmp_en,
    input  logic [ACC_W-1:0]   res_data,
    output logic               chk_err
);

    // One spare bit so model + operand never overflows before reduction.
    localparam int unsigned SUM_W = ACC_W + 1;

    logic [SUM_W-1:0] model_q, model_d;
    logic             err_q, err_d;
    logic [SUM_W-1:0] sum_c;
    logic [SUM_W-1:0] res_mod_c;

    // Model update and result comparison.
    always_comb begin
        model_d   = model_q;
        err_d     = err_q;
        sum_c     = model_q + SUM_W'(data);
        res_mod_c = SUM_W'(res_data) % SUM_W'(MODULUS);
        if (clr) begin
            model_d = '0;
        end else if (acc_en) begin
            model_d = sum_c % SUM_W'(MODULUS);
        end
        if (cmp_en && (res_mod_c != model_q)) begin
            err_d = 1'b1;
        end
    end

    // Model and sticky error registers; only reset clears the error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            model_q <= '0;
            err_q   <= 1'b0;
        end else begin
            model_q <= model_d;
            err_q   <= err_d;
        end
    end

    assign chk_err = err_q;

endmodule

// File: rtl/mod_accum_seq.sv
// Job sequencer for an external modular accumulator: flushes the pipeline,
// streams operands with staggered clear release and tail truncation control,
// waits for the drain latency, then holds the captured result for handoff.
// Optional checker: define MOD_ACCUM_SEQ_CHECK_EN to build mod_accum_golden.
module mod_accum_seq
    import mod_accum_pkg::*;
#(
    parameter int unsigned MODULUS    = MODULUS_DEFAULT,
    parameter int unsigned CLR_CYCLES = 5,
    parameter int unsigned TAIL_LEN   = 5,
    parameter int unsigned DRAIN_LAT  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   job_len,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIGIT_W-1:0] in_data,
    output logic [DIGIT_W-1:0] digit_in,
    output logic               clear_1,
    output logic               clear_2,
    output logic               clear_3,
    output logic               trunc_ena,
    input  logic [ACC_W-1:0]   accum,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ACC_W-1:0]   res_data,
    output logic               chk_err
);

    localparam int unsigned CNT_MAX = (CLR_CYCLES > DRAIN_LAT) ? CLR_CYCLES : DRAIN_LAT;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    acc_ctrl_t          ctl_q, ctl_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               res_valid_q, res_valid_d;
    logic [ACC_W-1:0]   res_data_q, res_data_d;
    logic               xfer_c;

    assign xfer_c = (state_q == ST_RUN) && in_valid && in_ready_q;

    // Next-state and registered-output decode.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rem_d           = rem_q;
        res_data_d      = res_data_q;
        res_valid_d     = res_valid_q;
        ctl_d           = ACC_CTRL_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FLUSH;
                    rem_d   = job_len;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == CNT_W'(CLR_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (rem_q == '0) ? ST_DRAIN : ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (xfer_c) begin
                    ctl_d.digit     = in_data;
                    ctl_d.trunc_ena = (rem_q > LEN_W'(TAIL_LEN));
                    rem_d           = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_LAT - 1)) begin
                    state_d     = ST_HOLD;
                    res_data_d  = accum;
                    res_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clears assert at once on IDLE/FLUSH but release one stage per cycle.
        ctl_d.clear_1 = (state_d == ST_IDLE) || (state_d == ST_FLUSH);
        ctl_d.clear_2 = ctl_d.clear_1 || ctl_q.clear_1;
        ctl_d.clear_3 = ctl_d.clear_2 || ctl_q.clear_2;

        in_ready_d = (state_d == ST_RUN) && (rem_d != '0);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any job in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            ctl_q       <= ACC_CTRL_IDLE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            ctl_q       <= ctl_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign digit_in  = ctl_q.digit;
    assign trunc_ena = ctl_q.trunc_ena;
    assign clear_1   = ctl_q.clear_1;
    assign clear_2   = ctl_q.clear_2;
    assign clear_3   = ctl_q.clear_3;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

`ifdef MOD_ACCUM_SEQ_CHECK_EN
    logic hold_entry_q, hold_entry_d;

    // Marks the first HOLD cycle, when res_data has just been captured.
    always_comb begin
        hold_entry_d = (state_q == ST_DRAIN) && (state_d == ST_HOLD);
    end

    // Registered HOLD-entry strobe for the checker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_entry_q <= 1'b0;
        end else begin
            hold_entry_q <= hold_entry_d;
        end
    end

    mod_accum_golden #(
        .MODULUS (MODULUS)
    ) u_golden (
        .clk      (clk),
        .reset    (reset),
        .clr      (state_q == ST_FLUSH),
        .acc_en   (xfer_c),
        .data     (in_data),
        .cmp_en   (hold_entry_q),
        .res_data (res_data_q),
        .chk_err  (chk_err)
    );
`else
    assign chk_err = 1'b0;
`endif

endmodule
